// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: backing-memory responder for the cache bus. It accepts one
// read or write transaction at a time and serves it from an internal RAM of
// 2^ADDR_WIDTH 32-bit words. A transaction is either a single beat or an INCR
// burst of len+1 beats.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   reset - synchronous, active-high reset
//   creq  - request from the arbiter (valid, is_write, size, addr, strobe,
//           data, len)
//   cresp - response beats (ready, last, data)
//
// Parameters:
//   ADDR_WIDTH - number of word-address bits
//   LATENCY    - wait cycles from request acceptance to the first beat (0..15)
//
// Timing: a request accepted at cycle T gives its first beat at T+1+LATENCY.
// Beats then follow back-to-back.
//
// Optional feature (macro CBUS_RAM_STALL_EN): when this macro is defined, one
// gap cycle is inserted after every beat of a burst except the last.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_ram_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  cbus_pkg::cbus_req_t  creq,
  output cbus_pkg::cbus_resp_t cresp
);

`ifdef CBUS_RAM_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Backing store. It is deliberately never reset, so its contents survive
  // the reset of the control logic.
  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [3:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [3:0]            beat_q, beat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  gap_q, gap_d;
  logic                  ready_q, ready_d;
  logic                  last_q, last_d;
  logic                  mem_we;

  // Only the word-index bits of addr are used. size never affects the RAM
  // access. This sink keeps the other bits from showing up as dangling logic.
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr};

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    mem_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (creq.valid) begin
          wr_d   = creq.is_write;
          len_d  = creq.len;
          ptr_d  = creq.addr[ADDR_WIDTH+1:2];
          beat_d = 4'd0;
          gap_d  = 1'b0;
          if (LATENCY == 0) begin
            state_d = ST_BURST;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end

      ST_WAIT: begin
        if (!creq.valid) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_BURST;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_BURST: begin
        if (!creq.valid) begin
          // Protocol violation: abandon the burst and do not write this beat.
          state_d = ST_IDLE;
          gap_d   = 1'b0;
        end else if (gap_q) begin
          // Stall cycle: the pointer is held and the next beat follows.
          gap_d = 1'b0;
        end else begin
          mem_we = wr_q;
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d  = ptr_q + 1'b1;
            beat_d = beat_q + 4'd1;
            gap_d  = STALL_EN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A write beat that coincides with reset must not reach the RAM.
    if (reset) mem_we = 1'b0;

    // ready and last are computed from the next state so that they leave this
    // block as flop outputs. This means creq has no path to them within a cycle.
    ready_d = (state_d == ST_BURST) && !gap_d;
    last_d  = ready_d && (beat_d == len_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      len_q   <= 4'd0;
      ptr_q   <= '0;
      beat_q  <= 4'd0;
      cnt_q   <= 4'd0;
      gap_q   <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      last_q  <= last_d;
    end
  end

  // Byte-masked write. The beat's data and strobe are sampled on the edge
  // that closes the beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (creq.strobe[i]) mem[ptr_q][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

  // Read data comes straight out of the RAM at the current pointer. The pointer
  // is a flop, so this path is still independent of creq.
  always_comb begin
    cresp       = '0;
    cresp.ready = ready_q;
    cresp.last  = last_q;
    if (ready_q && !wr_q) cresp.data = mem[ptr_q];
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
module tb_cbus_ram_responder;
  import cbus_pkg::*;

`ifdef CBUS_RAM_STALL_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq0, creq1;
  cbus_resp_t cresp0, cresp1;

  int tests = 0;
  int fails = 0;

  cbus_resp_t  exp_q[$];
  logic [31:0] m0 [65536];
  logic [31:0] m1 [16];

  // dut0: default geometry, LATENCY=2. dut1: 16-word RAM, LATENCY=0.
  cbus_ram_responder #(.ADDR_WIDTH(16), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .creq(creq0), .cresp(cresp0));
  cbus_ram_responder #(.ADDR_WIDTH(4), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset), .creq(creq1), .cresp(cresp1));

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input int sel, input int idx);
    return (sel != 0) ? m1[idx] : m0[idx];
  endfunction

  function automatic void model_write(input int sel, input int idx,
                                      input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = model_read(sel, idx);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    if (sel != 0) m1[idx] = w; else m0[idx] = w;
  endfunction

  task automatic chk(input string tag, input cbus_resp_t got, input cbus_resp_t e);
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s: got ready=%0b last=%0b data=%h, expected ready=%0b last=%0b data=%h",
             tag, got.ready, got.last, got.data, e.ready, e.last, e.data);
    end
  endtask

  task automatic drive(input int sel, input cbus_req_t r);
    if (sel != 0) creq1 = r; else creq0 = r;
  endtask

  // Runs one transaction. The expected response for every cycle is queued up
  // front, then popped and compared cycle by cycle. When abort_beat >= 0,
  // valid is dropped during that beat.
  task automatic run_txn(input string tag, input int sel, input bit wr,
                         input logic [31:0] addr, input int len, input logic [3:0] strb,
                         input logic [31:0] wbase, input logic [31:0] wstep,
                         input int abort_beat);
    int lat, mask, last_beat, total, kd, k, widx;
    cbus_resp_t e, got;
    cbus_req_t r;
    lat       = (sel != 0) ? 0 : 2;
    mask      = (sel != 0) ? 15 : 65535;
    last_beat = (abort_beat >= 0) ? abort_beat : len;
    total     = 1 + lat + GAP*last_beat + 1;
    for (int c = 1; c <= total; c++) begin
      e = '0;
      if (c >= 1 + lat && ((c - 1 - lat) % GAP) == 0 && (c - 1 - lat) / GAP <= last_beat) begin
        k    = (c - 1 - lat) / GAP;
        widx = (int'(addr >> 2) + k) & mask;
        e.ready = 1'b1;
        e.last  = (k == len);
        if (wr) begin
          if (k != abort_beat) model_write(sel, widx, wbase + wstep*k, strb);
        end else begin
          e.data = model_read(sel, widx);
        end
      end
      exp_q.push_back(e);
    end

    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = strb;
    r.len      = 4'(len);
    r.data     = wbase;
    drive(sel, r);
    @(posedge clk);
    kd = 0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = (sel != 0) ? cresp1 : cresp0;
      chk($sformatf("%s c%0d", tag, c), got, e);
      if (kd > last_beat || (e.ready && abort_beat >= 0 && kd == abort_beat)) r.valid = 1'b0;
      r.data = wbase + wstep*kd;
      drive(sel, r);
      if (e.ready) kd++;
    end
    r.valid = 1'b0;
    drive(sel, r);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    creq0 = '0;
    creq1 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset: no spurious response on either instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle0", cresp0, '0);
      chk("idle1", cresp1, '0);
    end

    // Single full-word write, then read it back.
    run_txn("wr100", 0, 1'b1, 32'h100, 0, 4'hF, 32'hDEADBEEF, 32'h0, -1);
    run_txn("rd100", 0, 1'b0, 32'h100, 0, 4'hF, 32'h0, 32'h0, -1);

    // Partial write with strobe 0101 over 0xAABBCCDD.
    run_txn("wr300", 0, 1'b1, 32'h300, 0, 4'hF, 32'hAABBCCDD, 32'h0, -1);
    run_txn("pwr300", 0, 1'b1, 32'h300, 0, 4'b0101, 32'h11223344, 32'h0, -1);
    run_txn("rd300", 0, 1'b0, 32'h300, 0, 4'hF, 32'h0, 32'h0, -1);

    // MLEN16 write of data k on beat k, then MLEN16 read, at LATENCY=2.
    run_txn("wr200x16", 0, 1'b1, 32'h200, 15, 4'hF, 32'h0, 32'h1, -1);
    run_txn("rd200x16", 0, 1'b0, 32'h200, 15, 4'hF, 32'h0, 32'h0, -1);

    // Same at LATENCY=0 on the 16-word instance, filling the whole RAM.
    run_txn("l0wr16", 1, 1'b1, 32'h0, 15, 4'hF, 32'h100, 32'h1, -1);
    run_txn("l0rd16", 1, 1'b0, 32'h0, 15, 4'hF, 32'h0, 32'h0, -1);

    // Wrap and aliasing: byte address 0x1038 is word index 14 in a 16-word RAM.
    run_txn("wrap4", 1, 1'b0, 32'h1038, 3, 4'hF, 32'h0, 32'h0, -1);

    // MLEN4 read at LATENCY=2 shows the beat pattern, including stall gaps when enabled.
    run_txn("rd200x4", 0, 1'b0, 32'h200, 3, 4'hF, 32'h0, 32'h0, -1);

    // Abort: fill 8 words, re-write them and drop valid on beat 2, then read back.
    run_txn("fill400", 0, 1'b1, 32'h400, 7, 4'hF, 32'hA0000000, 32'h1, -1);
    run_txn("abort400", 0, 1'b1, 32'h400, 7, 4'hF, 32'hB0000000, 32'h1, 2);
    run_txn("rd400x8", 0, 1'b0, 32'h400, 7, 4'hF, 32'h0, 32'h0, -1);

    // Reset asserted while a read sits in WAIT: no ready pulse may follow.
    creq0          = '0;
    creq0.valid    = 1'b1;
    creq0.is_write = 1'b0;
    creq0.addr     = 32'h100;
    @(posedge clk);
    @(negedge clk);
    chk("rstwait_pre", cresp0, '0);
    reset       = 1'b1;
    creq0.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rstwait_at", cresp0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstwait_post%0d", i), cresp0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
